// File: rtl/grf_hazard_ctrl.sv
// Stall/bypass scheduler for the shared GRF: tracks in-flight writers in E/M/W
// plus a mult/div busy counter, and drives the D-stage stall and operand bypass selects.
module grf_hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_a3,
  input  logic [1:0] d_tnew,
  input  logic       d_md_use,
  input  logic       e_md_start,
  input  logic       e_md_is_div,
  output logic       stall,
  output logic [1:0] d_fwd_rs,
  output logic [1:0] d_fwd_rt,
  output logic [1:0] e_fwd_rs,
  output logic [1:0] e_fwd_rt,
  output logic       md_busy
);

  logic       e_valid_q, e_valid_d;
  logic [4:0] e_a3_q, e_a3_d;
  logic [1:0] e_tnew_q, e_tnew_d;
  logic [4:0] e_rs_q, e_rs_d;
  logic [4:0] e_rt_q, e_rt_d;
  logic       m_valid_q, m_valid_d;
  logic [4:0] m_a3_q, m_a3_d;
  logic [1:0] m_tnew_q, m_tnew_d;
  logic       w_valid_q, w_valid_d;
  logic [4:0] w_a3_q, w_a3_d;
  logic [3:0] md_cnt_q, md_cnt_d;

  logic stall_rs, stall_rt, stall_md, stall_int;

  // Register 0 is hard-wired, so a writer of $0 never produces a dependency.
  function automatic logic hit(input logic v, input logic [4:0] a3, input logic [4:0] r);
    return v && (a3 == r) && (r != 5'd0);
  endfunction

  function automatic logic stall_op(input logic [4:0] r, input logic [1:0] tuse,
                                    input logic ev, input logic [4:0] ea3, input logic [1:0] etn,
                                    input logic mv, input logic [4:0] ma3, input logic [1:0] mtn);
    return (tuse != 2'd3) &&
           ((hit(ev, ea3, r) && (etn > tuse)) || (hit(mv, ma3, r) && (mtn > tuse)));
  endfunction

  function automatic logic [1:0] d_sel(input logic [4:0] r,
                                       input logic ev, input logic [4:0] ea3, input logic [1:0] etn,
                                       input logic mv, input logic [4:0] ma3, input logic [1:0] mtn);
    if (hit(ev, ea3, r) && (etn == 2'd0))      return 2'd2;
    else if (hit(mv, ma3, r) && (mtn == 2'd0)) return 2'd1;
    else                                       return 2'd0;
  endfunction

  function automatic logic [1:0] e_sel(input logic [4:0] r,
                                       input logic mv, input logic [4:0] ma3, input logic [1:0] mtn,
                                       input logic wv, input logic [4:0] wa3);
    if (hit(mv, ma3, r) && (mtn == 2'd0)) return 2'd1;
    else if (hit(wv, wa3, r))             return 2'd2;
    else                                  return 2'd0;
  endfunction

  always_comb begin
    stall_rs  = stall_op(d_rs, d_tuse_rs, e_valid_q, e_a3_q, e_tnew_q, m_valid_q, m_a3_q, m_tnew_q);
    stall_rt  = stall_op(d_rt, d_tuse_rt, e_valid_q, e_a3_q, e_tnew_q, m_valid_q, m_a3_q, m_tnew_q);
    stall_md  = d_md_use && ((md_cnt_q != 4'd0) || e_md_start);
    stall_int = stall_rs | stall_rt | stall_md;
  end

  // Outputs are held at zero for the whole time reset is asserted.
  always_comb begin
    stall    = 1'b0;
    d_fwd_rs = 2'd0;
    d_fwd_rt = 2'd0;
    e_fwd_rs = 2'd0;
    e_fwd_rt = 2'd0;
    md_busy  = 1'b0;
    if (reset) begin
      stall    = stall_int;
      d_fwd_rs = d_sel(d_rs, e_valid_q, e_a3_q, e_tnew_q, m_valid_q, m_a3_q, m_tnew_q);
      d_fwd_rt = d_sel(d_rt, e_valid_q, e_a3_q, e_tnew_q, m_valid_q, m_a3_q, m_tnew_q);
      e_fwd_rs = e_sel(e_rs_q, m_valid_q, m_a3_q, m_tnew_q, w_valid_q, w_a3_q);
      e_fwd_rt = e_sel(e_rt_q, m_valid_q, m_a3_q, m_tnew_q, w_valid_q, w_a3_q);
      md_busy  = (md_cnt_q != 4'd0);
    end
  end

  always_comb begin
    w_valid_d = m_valid_q;
    w_a3_d    = m_a3_q;
    m_valid_d = e_valid_q;
    m_a3_d    = e_a3_q;
    m_tnew_d  = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
    e_valid_d = 1'b0;
    e_a3_d    = 5'd0;
    e_tnew_d  = 2'd0;
    e_rs_d    = 5'd0;
    e_rt_d    = 5'd0;
    if (!stall_int) begin
      e_valid_d = 1'b1;
      e_a3_d    = d_a3;
      e_tnew_d  = d_tnew;
      e_rs_d    = d_rs;
      e_rt_d    = d_rt;
    end
    // A start while the unit is busy is dropped; the running count is not restarted.
    md_cnt_d = md_cnt_q;
    if (e_md_start && (md_cnt_q == 4'd0))
      md_cnt_d = e_md_is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    else if (md_cnt_q != 4'd0)
      md_cnt_d = md_cnt_q - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      e_valid_q <= 1'b0;
      e_a3_q    <= 5'd0;
      e_tnew_q  <= 2'd0;
      e_rs_q    <= 5'd0;
      e_rt_q    <= 5'd0;
      m_valid_q <= 1'b0;
      m_a3_q    <= 5'd0;
      m_tnew_q  <= 2'd0;
      w_valid_q <= 1'b0;
      w_a3_q    <= 5'd0;
      md_cnt_q  <= 4'd0;
    end else begin
      e_valid_q <= e_valid_d;
      e_a3_q    <= e_a3_d;
      e_tnew_q  <= e_tnew_d;
      e_rs_q    <= e_rs_d;
      e_rt_q    <= e_rt_d;
      m_valid_q <= m_valid_d;
      m_a3_q    <= m_a3_d;
      m_tnew_q  <= m_tnew_d;
      w_valid_q <= w_valid_d;
      w_a3_q    <= w_a3_d;
      md_cnt_q  <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_grf_hazard_ctrl.sv
// Directed bench for grf_hazard_ctrl: each cycle's stimulus pushes its expected
// output vector {stall, d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt, md_busy}; a monitor checks it.
module tb_grf_hazard_ctrl;

  localparam int W = 10;

  logic       clk;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_a3;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_use, e_md_start, e_md_is_div;
  logic       stall, md_busy;
  logic [1:0] d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks;
  int           failures;

  // staged D-stage instruction, applied by cyc()
  logic [4:0] s_rs, s_rt, s_a3;
  logic [1:0] s_tu_rs, s_tu_rt, s_tnew;
  logic       s_md_use;

  grf_hazard_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_a3       (d_a3),
    .d_tnew     (d_tnew),
    .d_md_use   (d_md_use),
    .e_md_start (e_md_start),
    .e_md_is_div(e_md_is_div),
    .stall      (stall),
    .d_fwd_rs   (d_fwd_rs),
    .d_fwd_rt   (d_fwd_rt),
    .e_fwd_rs   (e_fwd_rs),
    .e_fwd_rt   (e_fwd_rt),
    .md_busy    (md_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic st, input logic [1:0] drs, input logic [1:0] drt,
                                      input logic [1:0] ers, input logic [1:0] ert, input logic bz);
    return {st, drs, drt, ers, ert, bz};
  endfunction

  task automatic set_d(input logic [4:0] rs, input logic [1:0] tu_rs,
                       input logic [4:0] rt, input logic [1:0] tu_rt,
                       input logic [4:0] a3, input logic [1:0] tnew, input logic mdu);
    s_rs = rs; s_tu_rs = tu_rs; s_rt = rt; s_tu_rt = tu_rt;
    s_a3 = a3; s_tnew = tnew; s_md_use = mdu;
  endtask

  task automatic set_idle();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0);
  endtask

  // one clock of stimulus with its expected response
  task automatic cyc(input logic rst_n, input logic mds, input logic isdiv,
                     input logic [W-1:0] e, input string n);
    @(posedge clk);
    #1;
    reset = rst_n;
    e_md_start = mds;
    e_md_is_div = isdiv;
    d_rs = s_rs; d_tuse_rs = s_tu_rs; d_rt = s_rt; d_tuse_rt = s_tu_rt;
    d_a3 = s_a3; d_tnew = s_tnew; d_md_use = s_md_use;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e;
      logic [W-1:0] got;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      got = {stall, d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt, md_busy};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL %s got=%b expected=%b (stall,dfrs,dfrt,efrs,efrt,busy)", n, got, e);
      end
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    d_rs = 0; d_rt = 0; d_a3 = 0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; d_tnew = 0;
    d_md_use = 0; e_md_start = 0; e_md_is_div = 0;

    // reset: outputs forced low even with a would-stall request
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0), "reset_forced");
    set_idle();
    cyc(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0), "reset_idle");

    // load-use: lw $1 then addu $4,$1,$6
    set_d(5'd5, 2'd1, 5'd0, 2'd3, 5'd1, 2'd2, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0), "lw_issue");
    set_d(5'd1, 2'd1, 5'd6, 2'd1, 5'd4, 2'd1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0), "load_use_stall");
    cyc(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0), "load_use_release");
    set_idle();
    cyc(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 2, 0, 0), "load_use_e_from_w");

    // branch after ALU: addu $3 then beq $3,$9
    set_d(5'd7, 2'd1, 5'd8, 2'd1, 5'd3, 2'd1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0), "alu_issue");
    set_d(5'd3, 2'd0, 5'd9, 2'd0, 5'd0, 2'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0), "branch_stall");
    cyc(1'b1, 1'b0, 1'b0, mk(0, 1, 0, 0, 0, 0), "branch_d_from_m");

    // jal then jr $31 (beq now in E sees $3 in W)
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd31, 2'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 2, 0, 0), "jal_issue_e_from_w");
    set_d(5'd31, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, mk(0, 2, 0, 0, 0, 0), "jr_d_from_e");
    set_idle();
    cyc(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 1, 0, 0), "jr_e_from_m");

    // $0 destination never hits
    set_d(5'd10, 2'd1, 5'd11, 2'd1, 5'd0, 2'd1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0), "zero_dst_issue");
    set_d(5'd0, 2'd1, 5'd0, 2'd1, 5'd5, 2'd1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0), "zero_src_no_stall");

    // unused operand (tuse 3) and store data (tuse 2) against tnew 1 in E
    set_d(5'd5, 2'd3, 5'd5, 2'd2, 5'd0, 2'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0), "tuse_no_stall");
    set_idle();
    cyc(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 1, 1, 0), "e_both_from_m");

    // divide: mfhi held in D stalls 11 cycles
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'd1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, mk(1, 0, 0, 0, 0, 0), "div_start_stall");
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 1), "div_busy_stall");
    cyc(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0), "div_done");

    // mult: 6 stall cycles, a start while busy is ignored
    cyc(1'b1, 1'b1, 1'b0, mk(1, 0, 0, 0, 0, 0), "mult_start_stall");
    cyc(1'b1, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 1), "mult_busy_stall");
    cyc(1'b1, 1'b1, 1'b1, mk(1, 0, 0, 0, 0, 1), "mult_restart_ignored");
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 1), "mult_busy_stall");
    cyc(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0), "mult_done");

    // reset mid-divide
    set_idle();
    cyc(1'b1, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0), "div2_start");
    cyc(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1), "div2_busy");
    cyc(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1), "div2_busy");
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd6, 2'd1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1), "div2_busy_alu6");
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0), "mid_div_reset_forced");
    set_d(5'd6, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0), "post_reset_cleared");
    set_idle();
    cyc(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0), "post_reset_idle");

    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() != 0; i++)
      @(posedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
